// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: instruction field layout, opcodes
// and the control FSM state encoding.
package alu_seq_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned IMM_W   = 7;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 13;
  localparam int unsigned RD_MSB  = 12;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS_MSB  = 9;
  localparam int unsigned RS_LSB  = 7;
  localparam int unsigned RT_MSB  = 6;
  localparam int unsigned RT_LSB  = 4;
  localparam int unsigned IMM_MSB = 6;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_ADDI = 3'b001;
  localparam logic [OP_W-1:0] OP_SUBI = 3'b010;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WB   = 3'd3,
    HALT = 3'd4
  } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: register fields, sign-extended imm7 and
// opcode classification.
module instr_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned DW     = 16
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [REG_AW-1:0]  rd,
  output logic [REG_AW-1:0]  rs,
  output logic [REG_AW-1:0]  rt,
  output logic [DW-1:0]      imm,
  output logic               use_imm,
  output logic               is_legal,
  output logic               is_halt
);

  logic [OP_W-1:0] op;

  always_comb begin
    op       = instr[OP_MSB:OP_LSB];
    rd       = REG_AW'(instr[RD_MSB:RD_LSB]);
    rs       = REG_AW'(instr[RS_MSB:RS_LSB]);
    rt       = REG_AW'(instr[RT_MSB:RT_LSB]);
    imm      = {{(DW-IMM_W){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
    use_imm  = (op == OP_ADDI) || (op == OP_SUBI);
    is_legal = (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUBI);
    is_halt  = (op == OP_HALT);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM sequencing one instruction at a time through
// register-file read, ALU execute and writeback.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned DW     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [REG_AW-1:0]  rf_raddr_a,
  output logic [REG_AW-1:0]  rf_raddr_b,
  input  logic [DW-1:0]      rf_rdata_a,
  input  logic [DW-1:0]      rf_rdata_b,
  output logic               rf_we,
  output logic [REG_AW-1:0]  rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic [OP_W-1:0]    alu_opcode,
  input  logic [DW-1:0]      alu_result,
  input  logic               alu_zero,
  output logic               zflag,
  output logic               done,
  output logic               illegal,
  output logic               halted
);

  state_e state_q, state_d;

  logic [REG_AW-1:0] dec_rd, dec_rs, dec_rt;
  logic [DW-1:0]     dec_imm;
  logic              dec_use_imm, dec_is_legal, dec_is_halt;

  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DW-1:0]     imm_q, imm_d;
  logic              use_imm_q, use_imm_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_AW-1:0] raddr_a_q, raddr_a_d, raddr_b_q, raddr_b_d;
  logic [DW-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_opcode_q, alu_opcode_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]     rf_wdata_q, rf_wdata_d;
  logic              zero_q, zero_d;
  logic              zflag_q, zflag_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              halted_q, halted_d;
  logic              accept;

  instr_decode #(
    .REG_AW(REG_AW),
    .DW    (DW)
  ) u_decode (
    .instr   (instr),
    .rd      (dec_rd),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .imm     (dec_imm),
    .use_imm (dec_use_imm),
    .is_legal(dec_is_legal),
    .is_halt (dec_is_halt)
  );

  // Read addresses go out in the accept cycle so registered read data lands in READ.
  always_comb begin
    instr_ready = (state_q == IDLE);
    accept      = instr_ready && instr_valid;
    rf_raddr_a  = accept ? dec_rs : raddr_a_q;
    rf_raddr_b  = accept ? dec_rt : raddr_b_q;
  end

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    imm_d        = imm_q;
    use_imm_d    = use_imm_q;
    op_d         = op_q;
    raddr_a_d    = raddr_a_q;
    raddr_b_d    = raddr_b_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    zero_d       = zero_q;
    zflag_d      = zflag_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    halted_d     = halted_q;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          rd_d      = dec_rd;
          imm_d     = dec_imm;
          use_imm_d = dec_use_imm;
          op_d      = instr[OP_MSB:OP_LSB];
          raddr_a_d = dec_rs;
          raddr_b_d = dec_rt;
          if (dec_is_legal) begin
            state_d = READ;
          end else if (dec_is_halt) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      READ: begin
        alu_a_d      = rf_rdata_a;
        alu_b_d      = use_imm_q ? imm_q : rf_rdata_b;
        alu_opcode_d = op_q;
        state_d      = EXEC;
      end
      // Writeback controls are registered here so they are live throughout WB.
      EXEC: begin
        rf_wdata_d = alu_result;
        zero_d     = alu_zero;
        rf_waddr_d = rd_q;
        rf_we_d    = (rd_q != '0);
        done_d     = 1'b1;
        state_d    = WB;
      end
      WB: begin
        zflag_d = zero_q;
        state_d = IDLE;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_q         <= '0;
      imm_q        <= '0;
      use_imm_q    <= 1'b0;
      op_q         <= '0;
      raddr_a_q    <= '0;
      raddr_b_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      zero_q       <= 1'b0;
      zflag_q      <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      imm_q        <= imm_d;
      use_imm_q    <= use_imm_d;
      op_q         <= op_d;
      raddr_a_q    <= raddr_a_d;
      raddr_b_q    <= raddr_b_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      zero_q       <= zero_d;
      zflag_q      <= zflag_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      halted_q     <= halted_d;
    end
  end

  always_comb begin
    rf_we      = rf_we_q;
    rf_waddr   = rf_waddr_q;
    rf_wdata   = rf_wdata_q;
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    alu_opcode = alu_opcode_q;
    zflag      = zflag_q;
    done       = done_q;
    illegal    = illegal_q;
    halted     = halted_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: register-file and ALU environment, a cycle-timeline
// model of the instruction rules, and directed instruction vectors.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'd0;
  logic        instr_ready;
  logic [2:0]  rf_raddr_a, rf_raddr_b;
  logic [15:0] rf_rdata_a, rf_rdata_b;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        zflag, done, illegal, halted;

  alu_sequencer #(.REG_AW(3), .DW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_rdata_a (rf_rdata_a),
    .rf_rdata_b (rf_rdata_b),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .zflag      (zflag),
    .done       (done),
    .illegal    (illegal),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Environment: ALU and a register file with registered reads, r0 hardwired.
  assign alu_result = (alu_opcode == 3'b010) ? (alu_a - alu_b) : (alu_a + alu_b);
  assign alu_zero   = (alu_result == 16'd0);

  logic        pl_en = 1'b0;
  logic [2:0]  pl_addr = 3'd0;
  logic [15:0] pl_data = 16'd0;
  logic [15:0] rf_mem [8];

  always @(posedge clk) begin
    if (pl_en) rf_mem[pl_addr] <= pl_data;
    else if (rf_we && rf_waddr != 3'd0) rf_mem[rf_waddr] <= rf_wdata;
    rf_rdata_a <= (rf_raddr_a == 3'd0) ? 16'd0 : rf_mem[rf_raddr_a];
    rf_rdata_b <= (rf_raddr_b == 3'd0) ? 16'd0 : rf_mem[rf_raddr_b];
  end

  // Model: what each accepted instruction must produce, and in which cycle.
  function automatic logic [15:0] spec_result(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic [15:0] imm);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a + imm;
      3'b010:  return a - imm;
      default: return 16'd0;
    endcase
  endfunction

  logic [15:0] mrf [8];
  logic [2:0]  m_rd, m_rs, m_rt;
  logic [15:0] m_a, m_b, m_imm, m_res;
  assign m_rd  = instr[12:10];
  assign m_rs  = instr[9:7];
  assign m_rt  = instr[6:4];
  assign m_a   = (m_rs == 3'd0) ? 16'd0 : mrf[m_rs];
  assign m_b   = (m_rt == 3'd0) ? 16'd0 : mrf[m_rt];
  assign m_imm = {{9{instr[6]}}, instr[6:0]};
  assign m_res = spec_result(instr[15:13], m_a, m_b, m_imm);

  int          cyc = 0;
  int          busy_end = 0;
  int          wb_cycle = -1;
  int          ill_cycle = -1;
  int          zf_cycle = -1;
  logic        halted_m = 1'b0;
  logic        zflag_m = 1'b0;
  logic        zf_new = 1'b0;
  logic        wb_we = 1'b0;
  logic [2:0]  wb_addr = 3'd0;
  logic [15:0] wb_data = 16'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_m  <= 1'b0;
      zflag_m   <= 1'b0;
      busy_end  <= 0;
      wb_cycle  <= -1;
      ill_cycle <= -1;
      zf_cycle  <= -1;
      wb_we     <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (pl_en) mrf[pl_addr] <= pl_data;
      else if (cyc == wb_cycle && wb_we) mrf[wb_addr] <= wb_data;
      if (cyc + 1 == zf_cycle) zflag_m <= zf_new;
      if (instr_valid && !halted_m && cyc >= busy_end) begin
        case (instr[15:13])
          3'b000, 3'b001, 3'b010: begin
            wb_cycle <= cyc + 3;
            wb_we    <= (m_rd != 3'd0);
            wb_addr  <= m_rd;
            wb_data  <= m_res;
            busy_end <= cyc + 4;
            zf_cycle <= cyc + 4;
            zf_new   <= (m_res == 16'd0);
          end
          3'b111:  halted_m <= 1'b1;
          default: begin
            ill_cycle <= cyc + 1;
            busy_end  <= cyc + 1;
          end
        endcase
      end
    end
  end

  int          checks = 0;
  int          failures = 0;
  int          timeouts = 0;
  logic        lit_on = 1'b0;
  logic [15:0] lit_wdata = 16'd0;
  logic        lit_zf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : compare
    #7;
    forever begin
      @(negedge clk);
      chk("instr_ready", 32'(instr_ready), 32'(!halted_m && cyc >= busy_end));
      chk("rf_we", 32'(rf_we), 32'(cyc == wb_cycle && wb_we));
      chk("done", 32'(done), 32'(cyc == wb_cycle));
      chk("illegal", 32'(illegal), 32'(cyc == ill_cycle));
      chk("halted", 32'(halted), 32'(halted_m));
      chk("zflag", 32'(zflag), 32'(zflag_m));
      chk("timeout", 32'(timeouts), 32'd0);
      if (cyc == wb_cycle && wb_we) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(wb_addr));
        chk("rf_wdata", 32'(rf_wdata), 32'(wb_data));
      end
      if (lit_on && cyc == wb_cycle) begin
        chk("lit_model_wdata", 32'(wb_data), 32'(lit_wdata));
        if (wb_we) chk("lit_rf_wdata", 32'(rf_wdata), 32'(lit_wdata));
      end
      if (lit_on && cyc == wb_cycle + 1) chk("lit_zflag", 32'(zflag), 32'(lit_zf));
    end
  end

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic issue(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeouts++;
    else @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'h6490;
  endtask

  task automatic run(input logic [15:0] w, input logic lon, input logic [15:0] lw, input logic lz);
    lit_on    = lon;
    lit_wdata = lw;
    lit_zf    = lz;
    issue(w);
    repeat (4) @(posedge clk);
  endtask

  initial begin : stim
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < 8; i++) preload(3'(i), 16'(i * 7));
    preload(3'd1, 16'd10);
    preload(3'd2, 16'd20);
    preload(3'd5, 16'hFFF1);
    preload(3'd7, 16'd25);

    run(16'h0CA0, 1'b1, 16'd30, 1'b0);      // ADD  r3,r1,r2
    run(16'h3285, 1'b1, 16'hFFF6, 1'b0);    // ADDI r4,r5,+5
    run(16'h5B99, 1'b1, 16'd0, 1'b1);       // SUBI r6,r7,+25
    run(16'h6490, 1'b0, 16'd0, 1'b0);       // illegal op 011, zflag stays 1
    preload(3'd1, 16'd30);
    run(16'h54C0, 1'b1, 16'd94, 1'b0);      // SUBI r5,r1,-64
    preload(3'd6, 16'h7FFF);
    preload(3'd7, 16'd1);
    run(16'h1370, 1'b1, 16'h8000, 1'b0);    // ADD  r4,r6,r7 wraps
    run(16'h00A0, 1'b1, 16'd50, 1'b0);      // ADD  r0,r1,r2: done, no write
    run(16'h283F, 1'b1, 16'd63, 1'b0);      // ADDI r2,r0,+63

    // Back-to-back dependent pair: r3=r1+r2, then r4=r3+r3
    lit_on = 1'b0;
    issue(16'h0CA0);
    issue(16'h11B0);
    repeat (5) @(posedge clk);

    // HALT with instr_valid held high afterwards
    issue(16'hE000);
    instr_valid = 1'b1;
    instr       = 16'h0CA0;
    repeat (10) @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted during EXEC aborts the write
    issue(16'h0CA0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(16'h0CA0, 1'b1, 16'd93, 1'b0);      // r1=30 + r2=63

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control FSM that sequences the 16-bit signed ALU for one instruction at a time. It accepts an instruction word over a valid/ready handshake and reads two operands from an external register file. It then drives the ALU operands and opcode, captures the result and zero flag, and writes the result back. It sits between the fetch stage and the ALU/register-file datapath of the 16-bit processor.

## Interface
Parameters:
- `REG_AW`, 3: register-file address width (8 registers).
- `DW`, 16: datapath width; the ALU and register file are `DW` bits signed.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `instr_valid`  in  1  instruction word is valid.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `instr`  in  16  instruction word: [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [6:0] imm7 (signed).
- `rf_raddr_a` / `rf_raddr_b`  out  REG_AW  register-file read addresses. Read data is registered, with 1-cycle latency.
- `rf_rdata_a` / `rf_rdata_b`  in  DW  register-file read data.
- `rf_we`  out  1  write enable.
- `rf_waddr`  out  REG_AW  write address.
- `rf_wdata`  out  DW  write data.
- `alu_a` / `alu_b`  out  DW  ALU operands, registered.
- `alu_opcode`  out  3  ALU opcode, registered.
- `alu_result`  in  DW  ALU result, combinational from the ALU inputs.
- `alu_zero`  in  1  ALU zero flag, combinational from the ALU inputs.
- `zflag`  out  1  architectural zero flag.
- `done`  out  1  one-cycle pulse marking writeback of a legal instruction.
- `illegal`  out  1  one-cycle pulse for an illegal opcode.
- `halted`  out  1  high after a HALT instruction.

## Operation
- Opcodes:
  - 000 ADD: rd = rs + rt.
  - 001 ADDI: rd = rs + sext(imm7).
  - 010 SUBI: rd = rs − sext(imm7).
  - 111 HALT.
  - 011–110 are illegal.
- ALU operands:
  - `alu_opcode` equals `instr[15:13]` for ADD, ADDI and SUBI.
  - `alu_b` is `rf_rdata_b` for ADD and the 16-bit sign extension of imm7 for ADDI/SUBI. imm7 range is −64..+63.
  - Arithmetic wraps modulo 2^16. There is no overflow detection.
- FSM states:
  - IDLE: `instr_ready`=1. On `instr_valid`: latch `instr`, drive `rf_raddr_a`=rs and `rf_raddr_b`=rt. Legal arithmetic op → READ. HALT → HALT. Illegal → IDLE, with `illegal` pulsed in the next cycle.
  - READ: read data is valid. Register `alu_a`, `alu_b` and `alu_opcode` → EXEC.
  - EXEC: capture `alu_result` and `alu_zero` → WB.
  - WB: `rf_we`=1 with `rf_waddr`=rd and `rf_wdata`=captured result. `zflag` takes the captured zero. `done`=1 → IDLE.
  - HALT: `halted`=1 and `instr_ready`=0. Only reset leaves HALT.
- rd = 0: r0 is hardwired to zero, so `rf_we` stays 0 in WB. `zflag` and `done` still update.
- An illegal instruction performs no register-file write, leaves `zflag` unchanged, and does not pulse `done`.
- `instr` is ignored whenever `instr_ready`=0. `instr_valid` may be held high across cycles without side effects.

## Timing
- Handshake fires when `instr_valid` and `instr_ready` are both high at a rising edge (cycle N).
- Legal op:
  - READ at N+1, EXEC at N+2, WB at N+3: `rf_we` and `done` high during N+3.
  - `zflag` shows the new value from N+4.
  - `instr_ready` is high again at N+4.
  - Throughput is one instruction per 4 cycles.
- Illegal op: `illegal` is high during N+1, and `instr_ready` is high again in N+1.
- HALT: `halted` and `instr_ready`=0 from N+1.
- `instr_ready` is decoded from the state, with no registered delay.
- A writeback to rd at N+3 is visible to the read issued for an instruction accepted at N+4, because the register file writes on the N+3 edge.
- Reset values: state=IDLE, `instr_ready`=1, and all other outputs and the `alu_*`/`rf_*` registers = 0.
- Reset asserted mid-instruction aborts it immediately. No `rf_we` may be asserted while `rst_n`=0.

## Structure
- Package `alu_seq_pkg` holds:
  - Opcode constants: OP_ADD, OP_ADDI, OP_SUBI, OP_HALT.
  - Instruction field bit positions.
  - The state encoding: IDLE, READ, EXEC, WB, HALT.
- Sub-module `instr_decode`, purely combinational, produces: rd, rs, rt, sign-extended imm, use_imm, is_legal, is_halt.

## Test plan
- Reset then ADD: r1=10, r2=20, instr ADD r3,r1,r2 → exactly one `rf_we` at N+3 with waddr=3 and wdata=30; `done` pulses; `zflag`=0; `instr_ready` high again at N+4.
- ADDI r4,r5,+5 with r5=−15 → wdata=0xFFF6 (−10), `zflag`=0. Then SUBI r6,r7,+25 with r7=25 → wdata=0, `zflag`=1.
- SUBI with imm7=7'b1000000 (−64) and r1=30 → wdata=94. Also ADD 0x7FFF + 1 → wdata=0x8000, wrapping with no flag.
- Illegal op 011 → `illegal` pulse at N+1, no `rf_we`, `zflag` unchanged. Then ADD r0,r1,r2 → `done` pulses with no `rf_we`.
- HALT → `halted`=1 and `instr_ready`=0 while `instr_valid` is held high for 10 cycles. Then reset → `halted`=0 and `instr_ready`=1.
- `rst_n` dropped during EXEC → `rf_we` never asserts. After release, the sequencer is in IDLE and a new ADD completes normally.
